apb4_reg_slave: RTL

Parametrised APB4 slave protocol engine with an integrated register bank. It is the successor of the plain APB3 signal bundle. It adds PSTRB byte strobes, configurable wait states, slave-error generation and read-only register support. It is the bus front-end between the APB master (UVM driver) and UART control/status logic; it terminates every APB transfer and exposes register contents and write pulses to the core.

---
 rtl/apb4_reg_slave_if.sv | 26 ++
 rtl/apb4_reg_slave.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/apb4_reg_slave_if.sv
// APB4 bus bundle between one master and one register slave.
// The master drives address/control/write data; the slave answers with prdata/pready/pslverr.
interface apb4_reg_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_reg_slave.sv
// APB4 slave with a byte-strobed register bank and optional read-only slots.
// Transfers take 2+WAIT_STATES cycles; writes land one cycle after completion, with a matching wr_pulse.
module apb4_reg_slave #(
  parameter int                      ADDR_WIDTH  = 12,
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      NUM_REGS    = 16,
  parameter int                      WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]     RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0]   RESET_VAL   = '0
) (
  input  logic                           pclk,
  input  logic                           presetn,
  apb4_reg_slave_if.slave                apb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_d,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AL     = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [ADDR_WIDTH-1:0] dec_addr, dec_word;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_write, dec_misal, dec_range, dec_ro, dec_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] reg_word [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_en;
  logic                  raise, complete;

  // In IDLE the decode looks at the live bus so a zero-wait transfer can answer in its first access cycle.
  always_comb begin
    dec_addr  = (state_q == S_IDLE) ? apb.paddr  : addr_q;
    dec_write = (state_q == S_IDLE) ? apb.pwrite : write_q;
    dec_word  = dec_addr >> AL;
    dec_idx   = dec_word[IDX_W-1:0];
    dec_misal = |(dec_addr & ADDR_WIDTH'(STRB_W - 1));
    dec_range = (dec_word < ADDR_WIDTH'(NUM_REGS));
    dec_ro    = dec_range & RO_MASK[dec_idx];
    dec_err   = dec_misal | ~dec_range | (dec_write & dec_ro);
    rd_word   = dec_range ? reg_word[dec_idx] : '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    raise      = 1'b0;
    complete   = 1'b0;
    wr_en      = '0;

    case (state_q)
      S_IDLE: begin
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata;
          strb_d  = apb.pstrb;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
          raise   = (WAIT_STATES == 0);
        end
      end
      S_ACCESS: begin
        if (!apb.psel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (pready_q) begin
          // pready is held for one cycle only; without penable the transfer is dropped.
          complete = apb.penable;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (cnt_q <= 4'd1) begin
          raise = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (raise) begin
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      prdata_d  = (!dec_write && !dec_err) ? rd_word : '0;
    end

    // pslverr_q still holds this transfer's error verdict during the completion cycle.
    if (complete && write_q && !pslverr_q && (|strb_q))
      wr_en[dec_idx] = 1'b1;
    wr_pulse_d = wr_en;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_word[i] = ro_d[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] word_q, word_d;
      logic                  unused_ro;

      assign unused_ro = ^ro_d[i*DATA_WIDTH +: DATA_WIDTH];

      always_comb begin
        word_d = word_q;
        if (wr_en[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) word_d[b*8 +: 8] = wdata_q[b*8 +: 8];
          end
        end
      end

      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) word_q <= RESET_VAL;
        else          word_q <= word_d;
      end

      assign reg_word[i] = word_q;
    end
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = reg_word[i];
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign wr_pulse    = wr_pulse_q;

endmodule
